// File: rtl/sync_ram_pkg.sv
// Shared encodings for the sequence RAM with hardware clear engine.
package sync_ram_pkg;

  // Clear-engine FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Read-during-write behaviour selectors for the WRITE_FIRST parameter.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks the array one word per cycle after reset release
// or a clear request, and reports busy / completion to the RAM top.
module ram_clear_seq
  import sync_ram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy,
  output logic                  clear_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t state;

  // The clear strobe is simply "in ST_CLEAR"; clr_addr is always < DEPTH here.
  assign clr_we = (state == ST_CLEAR);

  // FSM, clear pointer and registered busy / clear_done flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      busy       <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= ST_IDLE;
            clr_addr   <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          if (clear) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sync_ram_seq_clear.sv
// Single-port synchronous RAM with registered read, read-valid strobe,
// selectable read-during-write mode and a sequenced hardware clear.
module sync_ram_seq_clear
  import sync_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    DEPTH       = 16,
  parameter int                    WRITE_FIRST = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  clear_done
);

  localparam bit WF_MODE = (WRITE_FIRST == RDW_WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  in_range;
  logic                  user_ok;
  logic                  user_we;
  logic                  user_re;

  ram_clear_seq #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .busy       (busy),
    .clear_done (clear_done)
  );

  // Addresses past DEPTH exist only when the array is not a power of two.
  if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_partial
    assign in_range = (address < ADDR_WIDTH'(DEPTH));
  end

  // User accesses are dropped while clearing and on the cycle a clear is accepted.
  assign user_ok = !busy && !clear;
  assign user_we = user_ok && write_enable && in_range;
  assign user_re = user_ok && read_enable;

  // Array write port: clear engine has the port while busy, user otherwise.
  // NOTE: the array has no reset so it maps onto block RAM; the clear engine
  // initialises it after reset release instead.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (user_we) begin
      mem[address] <= data_in;
    end
  end

  // Registered read data and one-cycle valid strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= user_re;
      if (user_re) begin
        if (!in_range) begin
          data_out <= CLEAR_VALUE;
        end else if (WF_MODE && user_we) begin
          data_out <= data_in;
        end else begin
          data_out <= mem[address];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_seq_clear.sv
// Directed bench: default build (a), write-first build (w) and a 12-word
// build (s) share one stimulus stream.
module tb_sync_ram_seq_clear;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       write_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic [3:0] address = '0;
  logic [3:0] data_in = '0;

  logic [3:0] dout_a, dout_w, dout_s;
  logic       rv_a, rv_w, rv_s;
  logic       busy_a, busy_w, busy_s;
  logic       done_a, done_w, done_s;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sync_ram_seq_clear dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .data_in(data_in),
    .data_out(dout_a), .read_valid(rv_a), .busy(busy_a), .clear_done(done_a)
  );

  sync_ram_seq_clear #(.WRITE_FIRST(1)) dut_w (
    .clock(clock), .reset(reset), .clear(clear),
    .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .data_in(data_in),
    .data_out(dout_w), .read_valid(rv_w), .busy(busy_w), .clear_done(done_w)
  );

  sync_ram_seq_clear #(.DEPTH(12)) dut_s (
    .clock(clock), .reset(reset), .clear(clear),
    .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .data_in(data_in),
    .data_out(dout_s), .read_valid(rv_s), .busy(busy_s), .clear_done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [3:0] d);
    write_enable = 1'b1; address = a; data_in = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] a, input logic [3:0] exp_a, input logic [3:0] exp_s);
    read_enable = 1'b1; address = a;
    tick();
    read_enable = 1'b0;
    check($sformatf("rv_a@%0d", a), rv_a, 1);
    check($sformatf("rv_s@%0d", a), rv_s, 1);
    check($sformatf("dout_a@%0d", a), dout_a, exp_a);
    check($sformatf("dout_w@%0d", a), dout_w, exp_a);
    check($sformatf("dout_s@%0d", a), dout_s, exp_s);
  endtask

  // Watch a clear sequence for 20 cycles while hammering accesses and a
  // repeated clear request that must all be ignored.
  task automatic run_clear(input string tag);
    int na = 0, ns = 0, nw = 0, pa = 0, ps = 0, va = 0, vs = 0;
    for (int i = 0; i < 20; i++) begin
      na += int'(busy_a); ns += int'(busy_s); nw += int'(busy_w);
      pa += int'(done_a); ps += int'(done_s);
      va += int'(rv_a);   vs += int'(rv_s);
      write_enable = (i < 10);
      read_enable  = (i < 10);
      clear        = (i == 3);
      address      = 4'(i);
      data_in      = 4'h5;
      tick();
    end
    write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0;
    check({tag, " busy_cycles_a"}, na, 16);
    check({tag, " busy_cycles_w"}, nw, 16);
    check({tag, " busy_cycles_s"}, ns, 12);
    check({tag, " done_pulses_a"}, pa, 1);
    check({tag, " done_pulses_s"}, ps, 1);
    check({tag, " valid_while_busy_a"}, va, 0);
    check({tag, " valid_while_busy_s"}, vs, 0);
  endtask

  initial begin
    // Reset state.
    tick(); tick();
    check("rst busy", busy_a, 1);
    check("rst dout", dout_a, 0);
    check("rst rv", rv_a, 0);
    check("rst done", done_a, 0);
    reset = 1'b1;
    run_clear("por");
    check("done_low_after", done_a, 0);

    // Power-on contents are all CLEAR_VALUE.
    for (int a = 0; a < 16; a++) read_word(4'(a), 4'h0, 4'h0);

    // Simple write then read, then an idle cycle holds data.
    write_word(4'd3, 4'hA);
    read_word(4'd3, 4'hA, 4'hA);
    tick();
    check("idle rv", rv_a, 0);
    check("idle dout", dout_a, 4'hA);

    // Same-cycle read and write to address 5.
    write_word(4'd5, 4'h2);
    write_enable = 1'b1; read_enable = 1'b1; address = 4'd5; data_in = 4'h7;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    check("rdw rv", rv_a, 1);
    check("rdw read_first", dout_a, 4'h2);
    check("rdw write_first", dout_w, 4'h7);
    check("rdw small", dout_s, 4'h2);
    read_word(4'd5, 4'h7, 4'h7);

    // Fill with F, then clear with a simultaneous write and read.
    for (int a = 0; a < 16; a++) write_word(4'(a), 4'hF);
    read_word(4'd9, 4'hF, 4'hF);
    read_word(4'd14, 4'hF, 4'h0);
    clear = 1'b1; write_enable = 1'b1; read_enable = 1'b1; address = 4'd0; data_in = 4'h1;
    tick();
    clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    check("clr dout_hold", dout_a, 4'hF);
    run_clear("clr");
    for (int a = 0; a < 16; a++) read_word(4'(a), 4'h0, 4'h0);

    // Reset in the middle of a clear.
    write_word(4'd2, 4'hC);
    read_word(4'd2, 4'hC, 4'hC);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    check("mid busy", busy_a, 1);
    check("mid dout_hold", dout_a, 4'hC);
    reset = 1'b0;
    #1;
    check("async busy", busy_a, 1);
    check("async dout", dout_a, 0);
    tick(); tick();
    reset = 1'b1;
    run_clear("rst");

    // Out-of-range access on the 12-word build.
    for (int a = 0; a < 16; a++) write_word(4'(a), 4'(a + 1));
    write_word(4'd13, 4'h9);
    for (int a = 0; a < 16; a++) begin
      logic [3:0] ea, es;
      ea = (a == 13) ? 4'h9 : 4'(a + 1);
      es = (a < 12) ? 4'(a + 1) : 4'h0;
      read_word(4'(a), ea, es);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
